fifo_ptr_ctrl: RTL and testbench

Parametrised pointer/status controller for the ALU FIFO: it generates the write and read addresses for the FIFO memory. It supports any MEMORY_DEPTH (not only powers of two) through wrap-bit pointers. It also qualifies write/read requests and produces full/empty, programmable almost-full/almost-empty and occupancy outputs. It sits between the FIFO memory array and the producer/consumer logic, replacing the standalone write-address counter.

---
 rtl/fifo_ctrl_pkg.sv | 28 ++
 rtl/fifo_wrap_ptr.sv | 37 +++
 rtl/fifo_ptr_ctrl.sv | 99 +++++++++
 tb/tb_fifo_ptr_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO pointer controller.
// Pointers carry an address plus a wrap bit so any depth (not only powers of two) works.
package fifo_ctrl_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;

    // Widest address a pointer can carry; depths up to 2**PTR_AW_MAX are supported.
    localparam int unsigned PTR_AW_MAX = 16;

    typedef struct packed {
        logic                  wrap;
        logic [PTR_AW_MAX-1:0] addr;
    } wrap_ptr_t;

    // Advance a pointer by one entry, folding back to 0 and toggling wrap at depth-1.
    function automatic wrap_ptr_t next_ptr(input wrap_ptr_t cur, input int unsigned depth);
        wrap_ptr_t nxt;
        if (cur.addr == PTR_AW_MAX'(depth - 1)) begin
            nxt.addr = '0;
            nxt.wrap = ~cur.wrap;
        end else begin
            nxt.addr = cur.addr + PTR_AW_MAX'(1);
            nxt.wrap = cur.wrap;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Enabled wrap counter: address 0..DEPTH-1 plus a toggle bit flipped on each wrap.
module fifo_wrap_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          wrap
);

    wrap_ptr_t cur;
    wrap_ptr_t nxt;

    // Next pointer value computed from the current registered pointer.
    always_comb begin
        cur      = '0;
        cur.wrap = wrap;
        cur.addr = PTR_AW_MAX'(addr);
        nxt      = next_ptr(cur, DEPTH);
    end

    // Pointer register, advancing only on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            addr <= AW'(nxt.addr);
            wrap <= nxt.wrap;
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/status controller: request qualification, addresses, occupancy and flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAG_EN is defined.
module fifo_ptr_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AFULL_LEVEL  = MEMORY_DEPTH - 1,
    parameter int unsigned AEMPTY_LEVEL = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_req,
    input  logic                               rd_req,
    output logic                               wr_en,
    output logic                               rd_en,
    output logic [$clog2(MEMORY_DEPTH)-1:0]    w_addr,
    output logic [$clog2(MEMORY_DEPTH)-1:0]    r_addr,
    output logic [$clog2(MEMORY_DEPTH):0]      count,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
`ifdef FIFO_ERR_FLAG_EN
    output logic                               almost_empty,
    output logic                               ovf,
    output logic                               udf
`else
    output logic                               almost_empty
`endif
);

    localparam int unsigned FIFO_ADDRESS_SIZE = $clog2(MEMORY_DEPTH);
    localparam int unsigned CW                = FIFO_ADDRESS_SIZE + 1;

    logic w_wrap;
    logic r_wrap;

    // Accept only what the registered state allows; a read never falls through an empty FIFO.
    always_comb begin
        wr_en = wr_req & ~full;
        rd_en = rd_req & ~empty;
    end

    fifo_wrap_ptr #(
        .DEPTH (MEMORY_DEPTH),
        .AW    (FIFO_ADDRESS_SIZE)
    ) u_wr_ptr (
        .clk  (clk),
        .rst  (rst),
        .en   (wr_en),
        .addr (w_addr),
        .wrap (w_wrap)
    );

    fifo_wrap_ptr #(
        .DEPTH (MEMORY_DEPTH),
        .AW    (FIFO_ADDRESS_SIZE)
    ) u_rd_ptr (
        .clk  (clk),
        .rst  (rst),
        .en   (rd_en),
        .addr (r_addr),
        .wrap (r_wrap)
    );

    // Occupancy counter: moves only when exactly one side is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Status flags decoded from registered pointers and count only.
    always_comb begin
        empty        = (w_addr == r_addr) & (w_wrap == r_wrap);
        full         = (w_addr == r_addr) & (w_wrap != r_wrap);
        almost_full  = 32'(count) >= AFULL_LEVEL;
        almost_empty = 32'(count) <= AEMPTY_LEVEL;
    end

`ifdef FIFO_ERR_FLAG_EN
    // Sticky error flags for requests made against a full or empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf | (wr_req & full);
            udf <= udf | (rd_req & empty);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed self-checking bench for fifo_ptr_ctrl (depth 4 and non-power-of-two depth 5).
module tb_fifo_ptr_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       wr4 = 1'b0, rd4 = 1'b0;
    logic       wen4, ren4, full4, empty4, af4, ae4;
    logic [1:0] wa4, ra4;
    logic [2:0] cnt4;

    logic       wr5 = 1'b0, rd5 = 1'b0;
    logic       wen5, ren5, full5, empty5, af5, ae5;
    logic [2:0] wa5, ra5;
    logic [3:0] cnt5;

`ifdef FIFO_ERR_FLAG_EN
    logic ovf4, udf4, ovf5, udf5;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(.MEMORY_DEPTH(4), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1)) u_d4 (
        .clk(clk), .rst(rst), .wr_req(wr4), .rd_req(rd4),
        .wr_en(wen4), .rd_en(ren4), .w_addr(wa4), .r_addr(ra4), .count(cnt4),
        .full(full4), .empty(empty4), .almost_full(af4),
`ifdef FIFO_ERR_FLAG_EN
        .almost_empty(ae4), .ovf(ovf4), .udf(udf4)
`else
        .almost_empty(ae4)
`endif
    );

    fifo_ptr_ctrl #(.MEMORY_DEPTH(5)) u_d5 (
        .clk(clk), .rst(rst), .wr_req(wr5), .rd_req(rd5),
        .wr_en(wen5), .rd_en(ren5), .w_addr(wa5), .r_addr(ra5), .count(cnt5),
        .full(full5), .empty(empty5), .almost_full(af5),
`ifdef FIFO_ERR_FLAG_EN
        .almost_empty(ae5), .ovf(ovf5), .udf(udf5)
`else
        .almost_empty(ae5)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_w_addr", 32'(wa4), 0);
        check("rst_r_addr", 32'(ra4), 0);
        check("rst_count", 32'(cnt4), 0);
        check("rst_empty", 32'(empty4), 1);
        check("rst_full", 32'(full4), 0);
        check("rst_aempty", 32'(ae4), 1);
        check("rst_afull", 32'(af4), 0);
        check("rst_afull5", 32'(af5), 0);
        tick();
        rst = 1'b0;

        // Depth 4: fill with four writes, w_addr 0,1,2,3 then 0
        for (int i = 0; i < 4; i++) begin
            wr4 = 1'b1;
            #1;
            check("fill_wr_en", 32'(wen4), 1);
            check("fill_w_addr", 32'(wa4), 32'(i));
            tick();
            check("fill_count", 32'(cnt4), 32'(i + 1));
            check("fill_afull", 32'(af4), (i + 1 >= 3) ? 1 : 0);
            check("fill_aempty", 32'(ae4), (i + 1 <= 1) ? 1 : 0);
        end
        check("full_w_addr", 32'(wa4), 0);
        check("full_flag", 32'(full4), 1);
        check("full_empty", 32'(empty4), 0);

        // Fifth write is rejected
        #1;
        check("ovf_wr_en", 32'(wen4), 0);
        tick();
        check("ovf_count", 32'(cnt4), 4);
        check("ovf_w_addr", 32'(wa4), 0);
`ifdef FIFO_ERR_FLAG_EN
        check("ovf_flag", 32'(ovf4), 1);
`endif

        // Full with both requests: only the read goes through
        rd4 = 1'b1;
        #1;
        check("fullrw_wr_en", 32'(wen4), 0);
        check("fullrw_rd_en", 32'(ren4), 1);
        tick();
        wr4 = 1'b0;
        rd4 = 1'b0;
        check("fullrw_count", 32'(cnt4), 3);
        check("fullrw_full", 32'(full4), 0);
        check("fullrw_r_addr", 32'(ra4), 1);

        // Asynchronous reset mid-cycle with count=3
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(cnt4), 0);
        check("arst_w_addr", 32'(wa4), 0);
        check("arst_r_addr", 32'(ra4), 0);
        check("arst_empty", 32'(empty4), 1);
        check("arst_full", 32'(full4), 0);
        check("arst_aempty", 32'(ae4), 1);
        check("arst_afull", 32'(af4), 0);
`ifdef FIFO_ERR_FLAG_EN
        check("arst_ovf", 32'(ovf4), 0);
        check("arst_udf", 32'(udf4), 0);
`endif
        tick();
        rst = 1'b0;

        // Empty with both requests: only the write goes through
        wr4 = 1'b1;
        rd4 = 1'b1;
        #1;
        check("emptyrw_wr_en", 32'(wen4), 1);
        check("emptyrw_rd_en", 32'(ren4), 0);
        tick();
        rd4 = 1'b0;
        check("emptyrw_count", 32'(cnt4), 1);
        check("emptyrw_empty", 32'(empty4), 0);
        check("emptyrw_r_addr", 32'(ra4), 0);
        check("emptyrw_aempty", 32'(ae4), 1);
`ifdef FIFO_ERR_FLAG_EN
        check("udf_flag", 32'(udf4), 1);
`endif

        // One more write: almost_empty drops at count 2
        tick();
        wr4 = 1'b0;
        check("ae_count", 32'(cnt4), 2);
        check("ae_fall", 32'(ae4), 0);
        check("ae_afull", 32'(af4), 0);

        // Depth 5: preload two entries, then stream write+read for 12 cycles
        wr5 = 1'b1;
        tick();
        tick();
        check("pre5_count", 32'(cnt5), 2);
        check("pre5_w_addr", 32'(wa5), 2);
        rd5 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            check("str5_en", 32'({wen5, ren5}), 3);
            tick();
            check("str5_w_addr", 32'(wa5), 32'((k + 3) % 5));
            check("str5_r_addr", 32'(ra5), 32'((k + 1) % 5));
            check("str5_count", 32'(cnt5), 2);
            check("str5_flags", 32'({full5, empty5}), 0);
        end
        wr5 = 1'b0;
        rd5 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
